// File: rtl/systemne_mem_test_master_if.sv
// Avalon-MM master bus bundle used by the memory test master.
interface systemne_mem_test_master_if #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                chipselect;
  logic                write;
  logic                read;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W-1:0]   readdata;
  logic                waitrequest;

  modport master (
    output address, byteenable, chipselect, write, read, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, byteenable, chipselect, write, read, writedata,
    output readdata, waitrequest
  );
endinterface

// File: rtl/systemne_mem_test_master.sv
// Memory fill-and-check master: writes a pattern over a word range, reads it back, counts mismatches.
// Optional macro MEMTEST_LFSR_PATTERN_EN selects a 32-bit Galois LFSR pattern instead of seed+i.
module systemne_mem_test_master #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_words,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  systemne_mem_test_master_if.master avm
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_FINISH} state_e;

  state_e state_q, state_d;

  logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [15:0]       err_q, err_d;
  logic [ADDR_W-1:0] ferr_q, ferr_d;
  logic              cs_q, cs_d, wr_q, wr_d, rd_q, rd_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d, base_q, base_d, exp_addr_q, exp_addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, seed_q, seed_d, pat_q, pat_d, exp_q, exp_d;
  logic [CNT_W-1:0]  num_q, num_d, idx_q, idx_d;
  logic              pend_q, pend_d;

  logic              accept_c, last_c;
  logic [CNT_W-1:0]  idx_nx_c;
  logic [ADDR_W-1:0] addr_nx_c;

  function automatic logic [DATA_W-1:0] pat_init(input logic [DATA_W-1:0] s);
`ifdef MEMTEST_LFSR_PATTERN_EN
    return (s == '0) ? DATA_W'(1) : s;
`else
    return s;
`endif
  endfunction

  function automatic logic [DATA_W-1:0] pat_next(input logic [DATA_W-1:0] p);
`ifdef MEMTEST_LFSR_PATTERN_EN
    return (p >> 1) ^ (p[0] ? DATA_W'(32'h8020_0003) : '0);
`else
    return p + DATA_W'(1);
`endif
  endfunction

  assign accept_c  = cs_q & ~avm.waitrequest;
  assign idx_nx_c  = idx_q + CNT_W'(1);
  assign last_c    = (idx_nx_c == num_q);
  assign addr_nx_c = base_q + idx_nx_c[ADDR_W-1:0];

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = (num_words == '0) ? S_FINISH : S_WRITE;
      S_WRITE:  if (accept_c && last_c) state_d = S_READ;
      S_READ:   if (accept_c && last_c) state_d = S_DRAIN;
      S_DRAIN:  state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    err_d      = err_q;
    ferr_d     = ferr_q;
    cs_d       = cs_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    be_d       = be_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    base_d     = base_q;
    num_d      = num_q;
    seed_d     = seed_q;
    idx_d      = idx_q;
    pat_d      = pat_q;
    exp_d      = exp_q;
    exp_addr_d = exp_addr_q;
    pend_d     = 1'b0;

    // Read data lands one cycle after its accept; compare against the value captured then
    if (pend_q && (avm.readdata != exp_q)) begin
      if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
      if (err_q == '0)       ferr_d = exp_addr_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          num_d   = num_words;
          seed_d  = seed;
          idx_d   = '0;
          pat_d   = pat_init(seed);
          err_d   = '0;
          ferr_d  = '0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          if (num_words != '0) begin
            cs_d    = 1'b1;
            wr_d    = 1'b1;
            be_d    = '1;
            addr_d  = base_addr;
            wdata_d = pat_init(seed);
          end
        end
      end
      S_WRITE: begin
        if (accept_c) begin
          if (last_c) begin
            idx_d  = '0;
            pat_d  = pat_init(seed_q);
            wr_d   = 1'b0;
            rd_d   = 1'b1;
            addr_d = base_q;
          end else begin
            idx_d   = idx_nx_c;
            pat_d   = pat_next(pat_q);
            wdata_d = pat_next(pat_q);
            addr_d  = addr_nx_c;
          end
        end
      end
      S_READ: begin
        if (accept_c) begin
          pend_d     = 1'b1;
          exp_d      = pat_q;
          exp_addr_d = addr_q;
          if (last_c) begin
            cs_d = 1'b0;
            rd_d = 1'b0;
            be_d = '0;
          end else begin
            idx_d  = idx_nx_c;
            pat_d  = pat_next(pat_q);
            addr_d = addr_nx_c;
          end
        end
      end
      S_FINISH: begin
        done_d = 1'b1;
        busy_d = 1'b0;
        pass_d = (err_q == '0);
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      ferr_q     <= '0;
      cs_q       <= 1'b0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      be_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      base_q     <= '0;
      num_q      <= '0;
      seed_q     <= '0;
      idx_q      <= '0;
      pat_q      <= '0;
      exp_q      <= '0;
      exp_addr_q <= '0;
      pend_q     <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      ferr_q     <= ferr_d;
      cs_q       <= cs_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      be_q       <= be_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      base_q     <= base_d;
      num_q      <= num_d;
      seed_q     <= seed_d;
      idx_q      <= idx_d;
      pat_q      <= pat_d;
      exp_q      <= exp_d;
      exp_addr_q <= exp_addr_d;
      pend_q     <= pend_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = ferr_q;
  assign avm.chipselect = cs_q;
  assign avm.write      = wr_q;
  assign avm.read       = rd_q;
  assign avm.byteenable = be_q;
  assign avm.address    = addr_q;
  assign avm.writedata  = wdata_q;

endmodule

// File: tb/tb_systemne_mem_test_master.sv
// Scoreboard bench for systemne_mem_test_master against an ideal latency-1 memory slave.
module tb_systemne_mem_test_master;

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DATA_W = 32;

  typedef struct {
    bit          wr;
    logic [12:0] addr;
    logic [31:0] data;
  } op_t;

  typedef struct {
    bit          pass;
    int          err;
    logic [12:0] ferr;
    longint      done_cyc;
  } res_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [12:0] base_addr = '0;
  logic [13:0] num_words = '0;
  logic [31:0] seed = '0;
  logic        busy, done, pass;
  logic [15:0] err_count;
  logic [12:0] first_err_addr;

  systemne_mem_test_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) avm_if ();

  systemne_mem_test_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .base_addr      (base_addr),
    .num_words      (num_words),
    .seed           (seed),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .avm            (avm_if)
  );

  always #5 clk = ~clk;

  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;
  int     done_cnt = 0;
  bit     mon_en = 1'b1;
  op_t    op_q[$];
  res_t   res_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pat_init(input logic [31:0] s);
`ifdef MEMTEST_LFSR_PATTERN_EN
    return (s == 32'd0) ? 32'd1 : s;
`else
    return s;
`endif
  endfunction

  function automatic logic [31:0] pat_next(input logic [31:0] p);
`ifdef MEMTEST_LFSR_PATTERN_EN
    return (p >> 1) ^ (p[0] ? 32'h8020_0003 : 32'h0);
`else
    return p + 32'd1;
`endif
  endfunction

  // Ideal slave with optional read corruption and a write stall
  logic [31:0] mem [0:8191];
  logic [31:0] rdata = '0;
  bit          slv_clr = 1'b0;
  bit          stall_en = 1'b0;
  bit          corrupt_en = 1'b0;
  logic [12:0] corrupt_addr = '0;
  int          wcnt = 0;
  int          stall_cnt = 0;
  logic        acc;

  assign avm_if.waitrequest = stall_en && avm_if.chipselect && avm_if.write &&
                              (wcnt == 1) && (stall_cnt < 3);
  assign avm_if.readdata = rdata;
  assign acc = avm_if.chipselect && !avm_if.waitrequest;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (slv_clr) begin
      wcnt      <= 0;
      stall_cnt <= 0;
    end else begin
      if (avm_if.waitrequest) stall_cnt <= stall_cnt + 1;
      if (acc && avm_if.write) begin
        mem[avm_if.address] <= avm_if.writedata;
        wcnt <= wcnt + 1;
      end
    end
    if (acc && avm_if.read)
      rdata <= mem[avm_if.address] ^
               ((corrupt_en && avm_if.address == corrupt_addr) ? 32'h1 : 32'h0);
  end

  // Bus monitor: pops the expected transfer on each accept, checks hold during stalls
  bit          hold_v = 1'b0;
  logic [12:0] hold_addr;
  logic [31:0] hold_data;
  always @(negedge clk) begin
    op_t e;
    if (mon_en && reset_n && avm_if.chipselect) begin
      check("be_ones", avm_if.byteenable, 4'hF);
      check("rw_excl", avm_if.write & avm_if.read, 1'b0);
      if (hold_v) begin
        check("hold_addr", avm_if.address, hold_addr);
        check("hold_data", avm_if.writedata, hold_data);
      end
      if (avm_if.waitrequest) begin
        hold_v    = 1'b1;
        hold_addr = avm_if.address;
        hold_data = avm_if.writedata;
      end else begin
        hold_v = 1'b0;
        if (op_q.size() == 0) check("extra_xfer", 1'b1, 1'b0);
        else begin
          e = op_q.pop_front();
          check("op_write", avm_if.write, e.wr);
          check("op_addr", avm_if.address, e.addr);
          if (e.wr) check("op_wdata", avm_if.writedata, e.data);
        end
      end
    end else hold_v = 1'b0;
  end

  // Done monitor: checks the run result and its cycle
  always @(negedge clk) begin
    res_t r;
    if (reset_n && done) begin
      done_cnt++;
      if (res_q.size() == 0) check("spurious_done", 1'b1, 1'b0);
      else begin
        r = res_q.pop_front();
        check("res_pass", pass, r.pass);
        check("res_err", err_count, 64'(r.err));
        check("res_ferr", first_err_addr, r.ferr);
        check("res_cycle", cyc, r.done_cyc);
        check("res_busy", busy, 1'b0);
      end
    end
  end

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt < target) check("done_timeout", 1'b0, 1'b1);
  endtask

  task automatic run(input logic [12:0] base, input logic [13:0] num, input logic [31:0] sd,
                     input int bad, input bit stall, input bit poke);
    logic [31:0] p;
    op_t  o;
    res_t r;
    int   target;
    corrupt_en   = (bad >= 0);
    corrupt_addr = base + 13'(bad);
    stall_en     = stall;
    p = pat_init(sd);
    for (int i = 0; i < int'(num); i++) begin
      o.wr = 1'b1; o.addr = base + 13'(i); o.data = p;
      op_q.push_back(o);
      p = pat_next(p);
    end
    for (int i = 0; i < int'(num); i++) begin
      o.wr = 1'b0; o.addr = base + 13'(i); o.data = '0;
      op_q.push_back(o);
    end
    @(posedge clk); #1;
    slv_clr = 1'b1; start = 1'b1; base_addr = base; num_words = num; seed = sd;
    r.pass     = (bad < 0);
    r.err      = (bad < 0) ? 0 : 1;
    r.ferr     = (bad < 0) ? 13'h0 : base + 13'(bad);
    r.done_cyc = cyc + ((num == 0) ? 2 : 2 * longint'(num) + 3) + ((stall && num > 1) ? 3 : 0);
    res_q.push_back(r);
    target = done_cnt + 1;
    @(posedge clk); #1;
    slv_clr = 1'b0;
    if (poke) begin
      base_addr = base ^ 13'h0F0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    wait_done(target, 4 * int'(num) + 40);
    check("ops_left", 64'(op_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_pass"}, pass, 1'b0);
    check({tag, "_err"}, err_count, 16'h0);
    check({tag, "_ferr"}, first_err_addr, 13'h0);
    check({tag, "_cs"}, avm_if.chipselect, 1'b0);
    check({tag, "_rdwr"}, {avm_if.read, avm_if.write}, 2'b00);
    check({tag, "_addr"}, avm_if.address, 13'h0);
    check({tag, "_wdata"}, avm_if.writedata, 32'h0);
  endtask

  initial begin
    int n;
    int dc;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_no_xfer", avm_if.chipselect, 1'b0);

    run(13'h0010, 14'd4, 32'h100, -1, 1'b0, 1'b0);
    run(13'h1FFE, 14'd4, 32'hABCD_0000, -1, 1'b0, 1'b0);
    run(13'h0020, 14'd6, 32'h1234_5678, 2, 1'b0, 1'b0);
    check("pass_held", pass, 1'b0);
    check("err_held", err_count, 16'd1);
    run(13'h0100, 14'd5, 32'h55, -1, 1'b1, 1'b0);
    run(13'h0200, 14'd0, 32'h77, -1, 1'b0, 1'b1);
    run(13'h0210, 14'd3, 32'h9000, -1, 1'b0, 1'b1);

    // Abort in the read phase
    mon_en = 1'b0;
    corrupt_en = 1'b0; stall_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 13'h0040; num_words = 14'd8; seed = 32'h4444;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!avm_if.read && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_read", avm_if.read, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    dc = done_cnt;
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_done", 64'(done_cnt), 64'(dc));
    check("abort_idle", avm_if.chipselect, 1'b0);
    reset_n = 1'b1;
    op_q.delete();
    mon_en = 1'b1;
    run(13'h0300, 14'd3, 32'hCAFE_0000, -1, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
